detection_logger: RTL

DETECTION_LOGGER -- requirements
Module: detection_logger

---
 rtl/detection_logger_pkg.sv | 11 +
 rtl/detection_logger_fifo.sv | 59 +++++
 rtl/detection_logger.sv | 97 +++++++++
 3 files changed

// File: rtl/detection_logger_pkg.sv
// Shared defaults and the timestamp type for the detection logger.
package detection_logger_pkg;

  localparam int TS_WIDTH_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 8;

  // Timestamp as logged at the default width.
  typedef logic [TS_WIDTH_DEF-1:0] ts_t;

endpackage : detection_logger_pkg

// File: rtl/detection_logger_fifo.sv
// Show-ahead event FIFO: head entry is visible on dout whenever not empty.
// A push while full is accepted only when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer and occupancy tracking; clear flushes without touching storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage is write-only on push; contents past the read pointer are don't-care.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= din;
  end

endmodule : event_fifo

// File: rtl/detection_logger.sv
// Timestamps rising edges of an upstream detector flag into a FIFO and keeps
// saturating event/drop statistics with a sticky overflow flag.
module detection_logger
  import detection_logger_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          detected,
  input  logic                          enable,
  input  logic                          clear,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [CNT_WIDTH-1:0]          event_count,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("detection_logger: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_det_prev;
  logic [CNT_WIDTH-1:0] r_event_count;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic                 r_overflow;

  logic w_event;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;

  // An event is a fresh rising edge while enabled; an event in a clear cycle is lost.
  assign w_event = detected && !r_det_prev && enable;
  assign w_pop   = !w_empty && evt_ready;
  assign w_push  = w_event && !clear && (!w_full || w_pop);
  assign w_drop  = w_event && !clear && w_full && !w_pop;

  assign evt_valid   = !w_empty;
  assign event_count = r_event_count;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;

  // Free-running timestamp; only reset stops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ts <= '0;
    else          r_ts <= r_ts + TS_WIDTH'(1);
  end

  // Previous-cycle detector level for edge detection; deliberately ignores clear and enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_det_prev <= 1'b0;
    else          r_det_prev <= detected;
  end

  // Saturating statistics and sticky overflow, flushed by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
    end else if (clear) begin
      r_event_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_event && r_event_count != '1) r_event_count <= r_event_count + CNT_WIDTH'(1);
      if (w_drop && r_drop_count != '1)   r_drop_count  <= r_drop_count + CNT_WIDTH'(1);
      if (w_drop)                         r_overflow    <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_ts),
    .dout    (evt_ts),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fill_level)
  );

endmodule : detection_logger
